// File: rtl/panel_bus_sequencer_pkg.sv
// panel_bus_pkg: shared types and constants for the front-panel bus master.
//   pb_state_e     - sequencer FSM state (IDLE/SETUP/STROBE/HOLD)
//   CH_*           - strobe-line / request-channel assignment on the panel board
//   max3()         - elaboration-time helper used to size the phase counter
package panel_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } pb_state_e;

  // Channel index of each peripheral strobe line.
  localparam int CH_MS6205_ADDR  = 0;
  localparam int CH_MS6205_DATA  = 1;
  localparam int CH_IN12_ANODE   = 2;
  localparam int CH_IN12_CATHODE = 3;
  localparam int CH_IN12_CLEAR   = 4;
  localparam int CH_KBD_WRITE    = 5;
  localparam int CH_KBD_READ     = 6;
  localparam int CH_KBD_CLEAR    = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/panel_bus_sequencer_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   req_i[N]          - request vector
//   grant_en_i        - a grant may be issued this cycle
//   grant_o[N]        - one-hot grant (zero when disabled or no request)
//   grant_idx_o       - encoded index of the winning request
//   grant_valid_o     - a request won this cycle (grant_o is non-zero)
// The pointer names the highest-priority channel. It moves to one past the
// winner only when a grant is actually issued, so a disabled cycle never
// disturbs fairness.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic                 grant_en_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 grant_valid_o
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic [IDX_W-1:0] win_idx;

  // Search ptr, ptr+1, ... wrapping at N. The sum needs one extra bit so
  // the wrap works for non-power-of-two N.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand_sum >= (IDX_W+1)'(N)) cand_sum = cand_sum - (IDX_W+1)'(N);
      cand = cand_sum[IDX_W-1:0];
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en_i && any_req) begin
      ptr_d = (win_idx == IDX_W'(N-1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign grant_valid_o = grant_en_i && any_req;
  assign grant_idx_o   = win_idx;
  assign grant_o       = grant_valid_o ? (N'(1) << win_idx) : '0;

endmodule

// File: rtl/panel_bus_sequencer.sv
// panel_bus_sequencer: front-panel bus master. Arbitrates NUM_CH request
// channels round-robin onto one shared DATA_W bus and runs each accepted
// transaction as SETUP (SETUP_CYC) / STROBE (STROBE_CYC) / HOLD (HOLD_CYC).
//   Clk, Rst        - clock, synchronous active-high reset
//   req_valid/read  - per-channel request and direction (1 = read)
//   req_data        - per-channel write data, channel c at [c*DATA_W +: DATA_W]
//   req_ready       - one-hot accept, combinational, only in IDLE
//   bus_data_out/oe - shared bus drive value and driver enable
//   bus_data_in     - bus readback, sampled on the last STROBE cycle of a read
//   strobe          - one-hot peripheral strobe
//   rd_data/rd_ch   - captured read data and its channel
//   rd_valid        - one-cycle pulse in the first HOLD cycle of a read
//   busy            - transaction in progress
//   state_dbg       - current FSM state
//
// Handshake: a request on channel c is accepted in the cycle where
// req_valid[c] && req_ready[c]. req_ready is only ever raised in IDLE, for
// exactly one channel; the request is captured that cycle, so the requester
// may drop or change req_valid/req_read/req_data afterwards.
module panel_bus_sequencer
  import panel_bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH-1:0]         req_read,
  input  logic [NUM_CH*DATA_W-1:0]  req_data,
  output logic [NUM_CH-1:0]         req_ready,
  output logic [DATA_W-1:0]         bus_data_out,
  output logic                      bus_data_oe,
  input  logic [DATA_W-1:0]         bus_data_in,
  output logic [NUM_CH-1:0]         strobe,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic                      busy,
  output logic [1:0]                state_dbg
);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  pb_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CH_W-1:0]      ch_q;
  logic                 read_q;
  logic [NUM_CH-1:0]    strobe_q;
  logic [DATA_W-1:0]    bus_out_q;
  logic                 oe_q;
  logic [DATA_W-1:0]    rd_data_q;
  logic                 rd_valid_q;
  logic [CH_W-1:0]      rd_ch_q;
  logic                 busy_q;

  logic                 arb_en;
  logic [NUM_CH-1:0]    arb_grant;
  logic [CH_W-1:0]      arb_idx;
  logic                 arb_valid;
  logic                 win_read;
  logic [DATA_W-1:0]    win_data;

  assign arb_en = (state_q == IDLE);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk_i         (Clk),
    .rst_i         (Rst),
    .req_i         (req_valid),
    .grant_en_i    (arb_en),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  assign win_read = req_read[arb_idx];
  assign win_data = req_data[int'(arb_idx)*DATA_W +: DATA_W];

  // Each phase reloads the shared counter with (length-1) on entry and
  // leaves when it reaches zero. Bus drive is decided at grant time and held
  // until the edge that returns to IDLE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      read_q     <= 1'b0;
      strobe_q   <= '0;
      bus_out_q  <= '0;
      oe_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q   <= SETUP;
            cnt_q     <= CNT_W'(SETUP_CYC - 1);
            ch_q      <= arb_idx;
            read_q    <= win_read;
            oe_q      <= !win_read;
            bus_out_q <= win_read ? '0 : win_data;
            busy_q    <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q  <= STROBE;
            cnt_q    <= CNT_W'(STROBE_CYC - 1);
            strobe_q <= NUM_CH'(1) << ch_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q  <= HOLD;
            cnt_q    <= CNT_W'(HOLD_CYC - 1);
            strobe_q <= '0;
            // Last strobe cycle: the peripheral has had the full strobe
            // width to drive the bus, so this is where read data is taken.
            if (read_q) begin
              rd_data_q  <= bus_data_in;
              rd_valid_q <= 1'b1;
              rd_ch_q    <= ch_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            oe_q      <= 1'b0;
            bus_out_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = arb_grant;
  assign strobe       = strobe_q;
  assign bus_data_out = bus_out_q;
  assign bus_data_oe  = oe_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_ch        = rd_ch_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_panel_bus_sequencer.sv
module tb_panel_bus_sequencer;
  import panel_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst;

  // default instance
  logic [7:0]  req_valid, req_read, req_ready, strobe;
  logic [63:0] req_data;
  logic [7:0]  bus_data_out, bus_data_in, rd_data;
  logic        bus_data_oe, rd_valid, busy;
  logic [2:0]  rd_ch;
  logic [1:0]  state_dbg;

  // minimal-timing instance
  logic [2:0]  s_req_valid, s_req_read, s_req_ready, s_strobe;
  logic [23:0] s_req_data;
  logic [7:0]  s_bus_data_out, s_bus_data_in, s_rd_data;
  logic        s_bus_data_oe, s_rd_valid, s_busy;
  logic [1:0]  s_rd_ch;
  logic [1:0]  s_state_dbg;

  panel_bus_sequencer u_dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_read(req_read),
    .req_data(req_data), .req_ready(req_ready), .bus_data_out(bus_data_out),
    .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in), .strobe(strobe),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ch(rd_ch), .busy(busy),
    .state_dbg(state_dbg)
  );

  panel_bus_sequencer #(.DATA_W(8), .NUM_CH(3), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_small (
    .Clk(Clk), .Rst(Rst), .req_valid(s_req_valid), .req_read(s_req_read),
    .req_data(s_req_data), .req_ready(s_req_ready), .bus_data_out(s_bus_data_out),
    .bus_data_oe(s_bus_data_oe), .bus_data_in(s_bus_data_in), .strobe(s_strobe),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_ch(s_rd_ch), .busy(s_busy),
    .state_dbg(s_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  int grant_cycles[4] = '{0, 9, 18, 27};

  initial begin
    Rst = 1'b1;
    req_valid = '0; req_read = '0; req_data = '0; bus_data_in = 8'hFF;
    s_req_valid = '0; s_req_read = '0; s_req_data = '0; s_bus_data_in = '0;
    tick();
    tick();

    // reset values
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_oe", 32'(bus_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_bus_out", 32'(bus_data_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_small_busy", 32'(s_busy), 32'd0);
    Rst = 1'b0;
    tick();

    // single write, channel 1, data A5
    req_data[CH_MS6205_DATA*8 +: 8] = 8'hA5;
    req_valid = 8'h02;
    #1;
    check("wr_ready", 32'(req_ready), 32'h02);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        check("wr_ready_ignored", 32'(req_ready), 32'h00);
        check("wr_state_setup", 32'(state_dbg), 32'(SETUP));
        req_valid = '0;
      end
      check($sformatf("wr_oe_c%0d", c), 32'(bus_data_oe), (c <= 8) ? 32'd1 : 32'd0);
      check($sformatf("wr_data_c%0d", c), 32'(bus_data_out), (c <= 8) ? 32'hA5 : 32'h00);
      check($sformatf("wr_strobe_c%0d", c), 32'(strobe), (c >= 3 && c <= 6) ? 32'h02 : 32'h00);
      check($sformatf("wr_busy_c%0d", c), 32'(busy), (c <= 8) ? 32'd1 : 32'd0);
    end

    // single read, channel 6, bus shows 3C only during strobe
    req_read = 8'h40;
    req_valid = 8'h40;
    #1;
    check("rd_ready", 32'(req_ready), 32'h40);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) req_valid = '0;
      if (c == 3) bus_data_in = 8'h3C;
      if (c == 7) bus_data_in = 8'hFF;
      check($sformatf("rd_oe_c%0d", c), 32'(bus_data_oe), 32'd0);
      check($sformatf("rd_strobe_c%0d", c), 32'(strobe), (c >= 3 && c <= 6) ? 32'h40 : 32'h00);
      check($sformatf("rd_valid_c%0d", c), 32'(rd_valid), (c == 7) ? 32'd1 : 32'd0);
      if (c == 7) begin
        check("rd_data", 32'(rd_data), 32'h3C);
        check("rd_ch", 32'(rd_ch), 32'(CH_KBD_READ));
      end
    end
    req_read = '0;

    // round robin over 0, 2, 7 held valid from reset
    do_reset();
    begin
      int ngr;
      int hi_cycles;
      int overlap;
      ngr = 0; hi_cycles = 0; overlap = 0;
      exp_q = '{8'd0, 8'd2, 8'd7, 8'd0};
      req_valid = 8'h85;
      #1;
      for (int c = 0; c <= 27; c++) begin
        if (c > 0) tick();
        if ((strobe & (strobe - 8'd1)) != 8'd0) overlap++;
        if (strobe != 8'd0) hi_cycles++;
        if (req_ready != 8'd0) begin
          if (exp_q.size() == 0) begin
            check("rr_extra_grant", 32'(req_ready), 32'd0);
          end else begin
            logic [7:0] g;
            g = exp_q.pop_front();
            check($sformatf("rr_grant%0d", ngr), 32'(req_ready), 32'(8'(1) << g));
            if (ngr < 4) check($sformatf("rr_cycle%0d", ngr), 32'(c), 32'(grant_cycles[ngr]));
          end
          ngr++;
        end
      end
      req_valid = '0;
      check("rr_grant_count", 32'(ngr), 32'd4);
      check("rr_strobe_cycles", 32'(hi_cycles), 32'd12);
      check("rr_overlap", 32'(overlap), 32'd0);
      tick();
      wait_idle();
    end

    // pointer wrap: after ch7, ch0 beats ch7
    req_valid = 8'h80;
    #1;
    check("wrap_first", 32'(req_ready), 32'h80);
    tick();
    req_valid = '0;
    wait_idle();
    req_valid = 8'h81;
    #1;
    check("wrap_second", 32'(req_ready), 32'h01);
    tick();
    req_valid = '0;
    wait_idle();

    // reset during STROBE of a read on ch0; pointer must return to ch0
    req_read = 8'h01;
    req_valid = 8'h01;
    #1;
    check("abort_ready", 32'(req_ready), 32'h01);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req_valid = '0;
    end
    check("abort_strobe_pre", 32'(strobe), 32'h01);
    Rst = 1'b1;
    tick();
    check("abort_strobe", 32'(strobe), 32'd0);
    check("abort_oe", 32'(bus_data_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    Rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        if (rd_valid) seen++;
        tick();
      end
      check("abort_no_rd_valid", 32'(seen), 32'd0);
    end
    req_read = '0;
    req_valid = 8'h05;
    #1;
    check("abort_next_grant", 32'(req_ready), 32'h01);
    tick();
    req_valid = '0;
    wait_idle();

    // minimal timing instance: 4-cycle transaction, single strobe cycle
    s_req_data = 24'h005A00;
    s_req_valid = 3'b010;
    #1;
    check("small_ready", 32'(s_req_ready), 32'h2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) s_req_valid = '0;
      check($sformatf("small_strobe_c%0d", c), 32'(s_strobe), (c == 2) ? 32'h2 : 32'h0);
      check($sformatf("small_busy_c%0d", c), 32'(s_busy), (c <= 3) ? 32'd1 : 32'd0);
      check($sformatf("small_oe_c%0d", c), 32'(s_bus_data_oe), (c <= 3) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/panel_bus_sequencer.md
# panel_bus_sequencer

Parametrised front-panel bus master for the emulator board: arbitrates up to NUM_CH peripheral request channels (MS6205 address/data, IN-12 anode/cathode/clear, keyboard write/read/clear) onto one shared DATA_W-bit bus. Each transaction is a setup / strobe / hold sequence with per-instance programmable cycle counts. Read transactions are supported and return captured bus data. It replaces the fixed single-strobe-per-line scheme with round-robin arbitration and configurable timing.

## Interface
Parameters:
- DATA_W, 8, shared bus width
- NUM_CH, 8, request channels / strobe lines
- SETUP_CYC, 2, cycles data is valid before strobe (>=1)
- STROBE_CYC, 4, strobe high cycles (>=1)
- HOLD_CYC, 2, cycles data is held after strobe (>=1)

Ports (one clock; reset is synchronous, active-high):
- Clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- req_valid  in  NUM_CH  per-channel request
- req_read  in  NUM_CH  1 = read transaction, 0 = write
- req_data  in  NUM_CH*DATA_W  write data, channel c at [c*DATA_W +: DATA_W]
- req_ready  out  NUM_CH  one-hot accept pulse
- bus_data_out  out  DATA_W  shared bus write value
- bus_data_oe  out  1  bus driver enable
- bus_data_in  in  DATA_W  bus readback
- strobe  out  NUM_CH  one-hot peripheral strobe
- rd_data  out  DATA_W  captured read data
- rd_valid  out  1  one-cycle read-complete pulse
- rd_ch  out  $clog2(NUM_CH)  channel of rd_data
- busy  out  1  transaction in progress (state != IDLE)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any req_valid, the arbiter picks channel g. req_ready[g]=1 combinationally that cycle. Latch g, req_read[g], and req_data slice. Next state SETUP.
- SETUP: SETUP_CYC cycles. Write: bus_data_oe=1 with the latched data. Read: bus_data_oe=0. Then STROBE.
- STROBE: STROBE_CYC cycles. strobe[g]=1, and only that bit. Bus is driven as in SETUP. On a read, bus_data_in is sampled into rd_data on the last STROBE cycle. Then HOLD.
- HOLD: HOLD_CYC cycles. strobe=0, bus kept as in SETUP. On a read, rd_valid=1 with rd_ch=g in the first HOLD cycle only. Then IDLE.
- Arbitration is round-robin. The search starts at (last_grant+1) mod NUM_CH and wraps. After reset the pointer makes channel 0 highest priority.
- The pointer updates only on a grant.
- Requests are ignored outside IDLE; req_ready stays 0 then.
- Deasserting req_valid after acceptance does not affect the transaction.
- A single shared down-counter, width $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1), is reloaded on each state entry.
- Reset values: state IDLE, strobe=0, bus_data_oe=0, bus_data_out=0, rd_data=0, rd_valid=0, rd_ch=0, req_ready=0, busy=0, pointer to channel 0.
- Reset mid-transaction: the next edge forces all reset values. strobe drops immediately and the in-flight transaction is lost with no rd_valid.

## Timing
- Transaction length: 1 (IDLE grant) + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles. Default is 9.
- Back-to-back: the next grant happens in the IDLE cycle immediately after HOLD, so there is at least one idle cycle between strobes.
- Strobe opens SETUP_CYC cycles after the grant cycle and closes HOLD_CYC cycles before IDLE.
- Read latency is grant + SETUP_CYC + STROBE_CYC + 1 cycles to rd_valid.
- Outputs strobe, bus_data_out, bus_data_oe, rd_* and busy are registered. req_ready is combinational from req_valid and state.

## Structure
- Package panel_bus_pkg holds:
  - state enum (IDLE/SETUP/STROBE/HOLD)
  - channel index constants CH_MS6205_ADDR=0, CH_MS6205_DATA=1, CH_IN12_ANODE=2, CH_IN12_CATHODE=3, CH_IN12_CLEAR=4, CH_KBD_WRITE=5, CH_KBD_READ=6, CH_KBD_CLEAR=7
- Sub-module rr_arbiter (parameter N) holds the round-robin pointer. Inputs: request vector and grant-enable. Outputs: one-hot grant and encoded index.

## Test plan
- Single write, defaults, ch1 data 8'hA5: req_ready[1] at cycle 0. oe=1 with 8'hA5 for cycles 1–8. strobe[1] high for cycles 3–6. busy low at cycle 9.
- Single read, ch6, bus_data_in=8'h3C during strobe: oe=0 throughout. rd_valid for one cycle at cycle 7 with rd_data=8'h3C, rd_ch=6.
- Channels 0, 2 and 7 all held valid: grants go in order 0, 2, 7, 0, with 9-cycle spacing and no strobe overlap.
- After one grant of ch7, channels 0 and 7 valid: ch0 is granted next (pointer wrap).
- Rst asserted during STROBE: strobe, oe and busy are 0 the next cycle. No rd_valid. The next grant goes to the lowest valid channel starting from 0.
- SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1, NUM_CH=3: transaction length is 4 cycles. strobe is high for exactly one cycle, at cycle 2.
